clock_enable_bank: RTL and testbench

//   Parametrised, multi-channel successor to the fixed divide-by-4 VGA clock divider.

---
 rtl/clock_enable_bank_if.sv | 30 +++
 rtl/clock_enable_bank.sv | 145 ++++++++++++++
 tb/tb_clock_enable_bank.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/clock_enable_bank_if.sv
// Bus bundle for clock_enable_bank: run enables, sync, divisor-write
// handshake and the per-channel tick / divided-clock / pending outputs.
interface clock_enable_bank_if #(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 16,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic [NUM_CH-1:0] ch_en;
    logic              sync;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [DIV_W-1:0]  cfg_div;
    logic              cfg_err;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] clk_div;
    logic [NUM_CH-1:0] pending;

    // Requester / timing consumer side
    modport master (
        output ch_en, sync, cfg_valid, cfg_ch, cfg_div,
        input  cfg_ready, cfg_err, tick, clk_div, pending
    );

    // Clock-enable bank side
    modport slave (
        input  ch_en, sync, cfg_valid, cfg_ch, cfg_div,
        output cfg_ready, cfg_err, tick, clk_div, pending
    );
endinterface

// File: rtl/clock_enable_bank.sv
// Multi-channel clock-enable generator. Each channel counts enabled edges
// and emits a one-cycle tick every div cycles plus a level that toggles on
// each tick. Divisor writes to a running channel are parked and applied on
// the channel's next terminal count so no period is ever shortened.

// One channel: counter, active/pending divisor, tick and divided level.
module clock_enable_bank_ch #(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_sync,
    input  logic             i_wr,
    input  logic [DIV_W-1:0] i_wr_div,
    output logic             o_tick,
    output logic             o_clk_div,
    output logic             o_pending
);
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div_active;
    logic [DIV_W-1:0] r_pend_div;
    logic             r_pending;
    logic             r_tick;
    logic             r_clk_div;
    logic             w_term;

    // div_active is never 0, so the subtraction cannot wrap
    assign w_term = (r_cnt == (r_div_active - DIV_W'(1)));

    // Priority: reset > sync > disabled > terminal count > count.
    // A write is only accepted while nothing is pending, so i_wr and
    // r_pending are never both set.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt        <= '0;
            r_div_active <= DIV_W'(DEFAULT_DIV);
            r_pend_div   <= DIV_W'(DEFAULT_DIV);
            r_pending    <= 1'b0;
            r_tick       <= 1'b0;
            r_clk_div    <= 1'b0;
        end else if (i_sync || !i_en) begin
            // Restart point: any new divisor can be applied without a runt
            r_cnt     <= '0;
            r_tick    <= 1'b0;
            r_clk_div <= 1'b0;
            r_pending <= 1'b0;
            if (i_wr) begin
                r_div_active <= i_wr_div;
            end else if (r_pending) begin
                r_div_active <= r_pend_div;
            end
        end else begin
            if (w_term) begin
                r_cnt     <= '0;
                r_tick    <= 1'b1;
                r_clk_div <= ~r_clk_div;
                // Period boundary: the parked divisor governs the next period
                if (r_pending) begin
                    r_div_active <= r_pend_div;
                    r_pending    <= 1'b0;
                end
            end else begin
                r_cnt  <= r_cnt + DIV_W'(1);
                r_tick <= 1'b0;
            end
            // Running channel: park the write, even on a terminal edge
            if (i_wr) begin
                r_pend_div <= i_wr_div;
                r_pending  <= 1'b1;
            end
        end
    end

    assign o_tick    = r_tick;
    assign o_clk_div = r_clk_div;
    assign o_pending = r_pending;
endmodule

// Bank top: shared divisor-write port decoded onto NUM_CH channels.
module clock_enable_bank #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 4
) (
    input  logic               CLK100MHZ,
    input  logic               reset_n,
    clock_enable_bank_if.slave bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CH_N = 1 << CH_W;

    logic [NUM_CH-1:0] w_pending;
    logic [NUM_CH-1:0] w_tick;
    logic [NUM_CH-1:0] w_clk_div;
    logic [NUM_CH-1:0] w_wr;
    logic [CH_N-1:0]   w_pend_pad;
    logic              w_in_range;
    logic              w_accept;
    logic [DIV_W-1:0]  w_div_sat;
    logic              r_cfg_err;

    // Channel indices beyond NUM_CH read as "not pending", so the port is
    // always ready for them and the bad write is consumed and flagged.
    assign w_pend_pad    = CH_N'(w_pending);
    assign bus.cfg_ready = ~w_pend_pad[bus.cfg_ch];
    assign w_in_range    = ({{(32-CH_W){1'b0}}, bus.cfg_ch} < 32'(NUM_CH));
    assign w_accept      = bus.cfg_valid & bus.cfg_ready;
    // A divisor of 0 behaves as 1
    assign w_div_sat     = (bus.cfg_div == '0) ? DIV_W'(1) : bus.cfg_div;

    // One-cycle error pulse for an accepted write to a missing channel
    always_ff @(posedge CLK100MHZ) begin
        if (!reset_n) begin
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= w_accept & ~w_in_range;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign w_wr[i] = w_accept & w_in_range & (bus.cfg_ch == CH_W'(i));

        clock_enable_bank_ch #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .i_clk     (CLK100MHZ),
            .i_rst_n   (reset_n),
            .i_en      (bus.ch_en[i]),
            .i_sync    (bus.sync),
            .i_wr      (w_wr[i]),
            .i_wr_div  (w_div_sat),
            .o_tick    (w_tick[i]),
            .o_clk_div (w_clk_div[i]),
            .o_pending (w_pending[i])
        );
    end

    assign bus.tick    = w_tick;
    assign bus.clk_div = w_clk_div;
    assign bus.pending = w_pending;
    assign bus.cfg_err = r_cfg_err;
endmodule

// File: tb/tb_clock_enable_bank.sv
// Bench for clock_enable_bank: directed scenarios then randomized traffic,
// all checked every cycle against a period-counting reference model.
// A second small instance covers the maximum divisor and a one-channel bank.
module tb_clock_enable_bank;
    localparam int NCH  = 5;
    localparam int DW   = 16;
    localparam int DDIV = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    clock_enable_bank_if #(.NUM_CH(NCH), .DIV_W(DW)) bus ();
    clock_enable_bank #(.NUM_CH(NCH), .DIV_W(DW), .DEFAULT_DIV(DDIV)) dut (
        .CLK100MHZ (clk),
        .reset_n   (rst_n),
        .bus       (bus)
    );

    clock_enable_bank_if #(.NUM_CH(1), .DIV_W(4)) bus2 ();
    clock_enable_bank #(.NUM_CH(1), .DIV_W(4), .DEFAULT_DIV(4)) dut2 (
        .CLK100MHZ (clk),
        .reset_n   (rst_n),
        .bus       (bus2)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: each channel counts edges into its current period
    int             m_div   [NCH];
    int             m_pdiv  [NCH];
    int             m_since [NCH];
    logic [NCH-1:0] m_pend, m_tick, m_lvl;
    logic           m_err;

    function automatic logic m_ready();
        int ch = int'(bus.cfg_ch);
        return (ch >= NCH) ? 1'b1 : !m_pend[ch];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NCH; i++) begin
            m_div[i] = DDIV; m_pdiv[i] = DDIV; m_since[i] = 0;
        end
        m_pend = '0; m_tick = '0; m_lvl = '0; m_err = 1'b0;
    endtask

    task automatic m_step();
        int   ch, sd;
        logic acc, wr;
        if (!rst_n) begin
            m_reset();
            return;
        end
        ch    = int'(bus.cfg_ch);
        acc   = bus.cfg_valid && m_ready();
        sd    = (bus.cfg_div == '0) ? 1 : int'(bus.cfg_div);
        m_err = acc && (ch >= NCH);
        for (int i = 0; i < NCH; i++) begin
            wr = acc && (ch == i);
            if (bus.sync || !bus.ch_en[i]) begin
                m_since[i] = 0; m_tick[i] = 1'b0; m_lvl[i] = 1'b0;
                if (wr) m_div[i] = sd;
                else if (m_pend[i]) m_div[i] = m_pdiv[i];
                m_pend[i] = 1'b0;
            end else begin
                m_since[i]++;
                if (m_since[i] == m_div[i]) begin
                    m_since[i] = 0; m_tick[i] = 1'b1; m_lvl[i] = ~m_lvl[i];
                    if (m_pend[i]) begin m_div[i] = m_pdiv[i]; m_pend[i] = 1'b0; end
                end else begin
                    m_tick[i] = 1'b0;
                end
                if (wr) begin m_pdiv[i] = sd; m_pend[i] = 1'b1; end
            end
        end
    endtask

    // One clock: check ready, take the edge, check registered outputs
    task automatic cyc();
        #1 chk("cfg_ready", bus.cfg_ready, m_ready());
        @(posedge clk);
        m_step();
        @(negedge clk);
        chk("tick", bus.tick, m_tick);
        chk("clk_div", bus.clk_div, m_lvl);
        chk("pending", bus.pending, m_pend);
        chk("cfg_err", bus.cfg_err, m_err);
    endtask

    task automatic cyc2();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic acc;

    initial begin
        bus.ch_en = '0; bus.sync = 1'b0; bus.cfg_valid = 1'b0;
        bus.cfg_ch = '0; bus.cfg_div = '0;
        bus2.ch_en = '0; bus2.sync = 1'b0; bus2.cfg_valid = 1'b0;
        bus2.cfg_ch = '0; bus2.cfg_div = '0;

        @(posedge clk);
        m_reset();
        @(negedge clk);
        chk("rst_tick", bus.tick, 0);
        chk("rst_pend", bus.pending, 0);

        // Default divisor from reset release
        bus.ch_en = 5'b00001;
        cyc();
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            chk("t1_tick", bus.tick[0], (k % 4) == 0);
            chk("t1_clk", bus.clk_div[0], (k / 4) % 2);
        end
        chk("t1_other", {bus.tick[NCH-1:1], bus.clk_div[NCH-1:1]}, 0);

        // Divisor change while running waits for the period boundary
        for (int j = 1; j <= 16; j++) begin
            if (j == 2) begin bus.cfg_valid = 1'b1; bus.cfg_ch = 0; bus.cfg_div = 6; end
            if (j == 3) begin
                bus.cfg_valid = 1'b0;
                #1 chk("t2_ready", bus.cfg_ready, 0);
            end
            cyc();
            chk("t2_tick", bus.tick[0], (j == 4) || (j == 10) || (j == 16));
            chk("t2_pend", bus.pending[0], (j == 2) || (j == 3));
        end

        // Zero divisor on a disabled channel -> tick every cycle
        bus.cfg_valid = 1'b1; bus.cfg_ch = 1; bus.cfg_div = 0;
        cyc();
        bus.cfg_valid = 1'b0;
        bus.ch_en = 5'b00011;
        for (int j = 1; j <= 6; j++) begin
            cyc();
            chk("t3_tick", bus.tick[1], 1);
            chk("t3_clk", bus.clk_div[1], j % 2);
        end

        // Sync realigns div 3 and div 5
        bus.cfg_valid = 1'b1; bus.cfg_ch = 1; bus.cfg_div = 5;
        cyc();
        bus.cfg_ch = 0; bus.cfg_div = 3; bus.sync = 1'b1;
        cyc();
        bus.cfg_valid = 1'b0; bus.sync = 1'b0;
        for (int j = 1; j <= 15; j++) begin
            cyc();
            chk("t4_tick0", bus.tick[0], (j % 3) == 0);
            chk("t4_tick1", bus.tick[1], (j % 5) == 0);
        end

        // Write to a missing channel
        bus.cfg_valid = 1'b1; bus.cfg_ch = 5; bus.cfg_div = 9;
        #1 chk("t5_ready", bus.cfg_ready, 1);
        cyc();
        chk("t5_err", bus.cfg_err, 1);
        bus.cfg_valid = 1'b0;
        cyc();
        chk("t5_err_clr", bus.cfg_err, 0);

        // Reset while a write is parked
        bus.cfg_valid = 1'b1; bus.cfg_ch = 0; bus.cfg_div = 7;
        cyc();
        bus.cfg_valid = 1'b0;
        chk("t6_pend", bus.pending[0], 1);
        rst_n = 1'b0;
        cyc();
        chk("t6_outs", {bus.tick, bus.clk_div, bus.pending, bus.cfg_err}, 0);
        rst_n = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            cyc();
            chk("t6_tick0", bus.tick[0], (j % 4) == 0);
            chk("t6_tick1", bus.tick[1], (j % 4) == 0);
        end

        // Randomized traffic with a well-behaved requester
        for (int n = 0; n < 2000; n++) begin
            if (!bus.cfg_valid && $urandom_range(3) == 0) begin
                bus.cfg_valid = 1'b1;
                bus.cfg_ch    = 3'($urandom_range(7));
                bus.cfg_div   = 16'($urandom_range(9));
            end
            bus.sync = ($urandom_range(60) == 0);
            if ($urandom_range(40) == 0) bus.ch_en = 5'($urandom);
            rst_n = ($urandom_range(300) != 0);
            acc = bus.cfg_valid && m_ready();
            cyc();
            if (acc) bus.cfg_valid = 1'b0;
        end
        rst_n = 1'b1; bus.sync = 1'b0; bus.cfg_valid = 1'b0;

        // Maximum divisor on a 4-bit, one-channel bank
        bus2.cfg_valid = 1'b1; bus2.cfg_ch = 0; bus2.cfg_div = 4'd15;
        cyc2();
        bus2.cfg_valid = 1'b0; bus2.ch_en = 1'b1;
        for (int j = 1; j <= 30; j++) begin
            cyc2();
            chk("max_tick", bus2.tick[0], (j % 15) == 0);
        end
        bus2.cfg_valid = 1'b1; bus2.cfg_ch = 1; bus2.cfg_div = 4'd2;
        #1 chk("b2_ready", bus2.cfg_ready, 1);
        cyc2();
        bus2.cfg_valid = 1'b0;
        chk("b2_err", bus2.cfg_err, 1);
        chk("b2_pend", bus2.pending, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
